ofdm_cp_remover: RTL and testbench

//  Sits directly downstream of the Schmidl & Cox frame-sync output (o_tdata/o_tlast).

---
 rtl/ofdm_cp_remover_if.sv | 40 ++++
 rtl/ofdm_cp_remover.sv | 195 +++++++++++++++++++
 tb/tb_ofdm_cp_remover.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ofdm_cp_remover_if.sv
// ---------------------------------------------------------------------------
// ofdm_cp_remover_if
//   AXI-Stream style sample bus shared by the CP remover's input and output.
//   One instance carries one direction of traffic.
//
//   Signals
//     tdata   WIDTH  sample (I in the upper half, Q in the lower half)
//     tlast   1      last beat (end of frame on the input side, end of
//                    symbol on the output side)
//     tvalid  1      source has a beat
//     tready  1      sink accepts the beat
//
//   Modports
//     master  drives tdata/tlast/tvalid, observes tready
//     slave   observes tdata/tlast/tvalid, drives tready
// ---------------------------------------------------------------------------
interface ofdm_cp_remover_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] tdata;
  logic             tlast;
  logic             tvalid;
  logic             tready;

  modport master (
    output tdata,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tlast,
    input  tvalid,
    output tready
  );

endinterface : ofdm_cp_remover_if

// File: rtl/ofdm_cp_remover.sv
// ---------------------------------------------------------------------------
// ofdm_cp_remover
//   Removes the cyclic prefix from every OFDM symbol of a frame and forwards
//   the FFT_LEN useful samples of each symbol as one packet (tlast per
//   symbol). Symbol timing restarts at every input frame boundary. The CP
//   length is captured on the first accepted sample of a frame and held for
//   the whole frame.
//
//   Ports
//     clk        clock
//     reset      asynchronous, active-high reset
//     clear      synchronous clear, same effect as reset
//     cp_len     CP samples to drop per symbol (sampled at frame start)
//     i_axis     input sample stream (slave), tlast marks end of frame
//     o_axis     output sample stream (master), tlast marks end of symbol
//                or of a truncated symbol
//     o_teof     qualifies o_axis.tlast: this symbol ends the frame
//     sym_count  full symbols emitted in the current frame (saturating)
//     trunc_err  one-cycle pulse: the frame ended part-way through a symbol
//
//   Data path: one output register, 1-cycle latency, full throughput.
// ---------------------------------------------------------------------------
module ofdm_cp_remover #(
  parameter int WIDTH       = 32,
  parameter int FFT_LEN     = 64,
  parameter int MAX_CP_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [MAX_CP_LOG2-1:0] cp_len,
  ofdm_cp_remover_if.slave       i_axis,
  ofdm_cp_remover_if.master      o_axis,
  output logic                   o_teof,
  output logic [15:0]            sym_count,
  output logic                   trunc_err
);

  // The sample counter must index both the CP and the useful part.
  localparam int FFT_W = (FFT_LEN > 1) ? $clog2(FFT_LEN) : 1;
  localparam int CNT_W = (MAX_CP_LOG2 > FFT_W) ? MAX_CP_LOG2 : FFT_W;

  typedef enum logic [0:0] {
    S_CP   = 1'b0,
    S_DATA = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [MAX_CP_LOG2-1:0] r_cp_lat;
  logic                   r_frame_start;
  logic [WIDTH-1:0]       r_tdata;
  logic                   r_tlast;
  logic                   r_teof;
  logic                   r_tvalid;
  logic [15:0]            r_sym_count;
  logic                   r_trunc_err;

  // -------------------------------------------------------------------------
  // Combinational control
  // -------------------------------------------------------------------------
  logic [MAX_CP_LOG2-1:0] w_cp_eff;
  logic                   w_in_data;
  logic                   w_out_free;
  logic                   w_in_ready;
  logic                   w_accept;
  logic                   w_cp_end;
  logic                   w_sym_end;
  logic [15:0]            w_sym_base;
  logic [15:0]            w_sym_inc;

  // On the first sample of a frame the live cp_len applies, since the
  // latched copy is only written by that same accept.
  assign w_cp_eff = r_frame_start ? cp_len : r_cp_lat;

  // A frame with zero CP treats its very first sample as useful data.
  assign w_in_data = (r_state == S_DATA) || (r_frame_start && (cp_len == '0));

  // Output register can take a new beat if empty or being drained now.
  assign w_out_free = ~r_tvalid | o_axis.tready;

  // CP samples are discarded, so they never wait on the output side.
  assign w_in_ready = w_in_data ? w_out_free : 1'b1;
  assign w_accept   = i_axis.tvalid & w_in_ready;

  // w_cp_eff is non-zero whenever the CP branch is taken.
  assign w_cp_end  = (r_cnt == (CNT_W'(w_cp_eff) - CNT_W'(1)));
  assign w_sym_end = (r_cnt == CNT_W'(FFT_LEN - 1));

  // The count restarts with the first sample of a new frame, so the value
  // from the previous frame is held until that sample arrives.
  assign w_sym_base = r_frame_start ? 16'd0 : r_sym_count;
  assign w_sym_inc  = (w_sym_base == 16'hFFFF) ? w_sym_base : (w_sym_base + 16'd1);

  // -------------------------------------------------------------------------
  // FSM and output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_CP;
      r_cnt         <= '0;
      r_cp_lat      <= '0;
      r_frame_start <= 1'b1;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_teof        <= 1'b0;
      r_tvalid      <= 1'b0;
      r_sym_count   <= 16'd0;
      r_trunc_err   <= 1'b0;
    end else if (clear) begin
      r_state       <= S_CP;
      r_cnt         <= '0;
      r_cp_lat      <= '0;
      r_frame_start <= 1'b1;
      r_tdata       <= '0;
      r_tlast       <= 1'b0;
      r_teof        <= 1'b0;
      r_tvalid      <= 1'b0;
      r_sym_count   <= 16'd0;
      r_trunc_err   <= 1'b0;
    end else begin
      r_trunc_err <= 1'b0;

      // Drain; a load below in the same cycle overrides this.
      if (r_tvalid && o_axis.tready) begin
        r_tvalid <= 1'b0;
      end

      if (w_accept) begin
        if (r_frame_start) begin
          r_cp_lat      <= cp_len;
          r_frame_start <= 1'b0;
          r_sym_count   <= 16'd0;
        end

        if (!w_in_data) begin
          // ---------------- CP: sample is dropped ----------------
          if (i_axis.tlast) begin
            // Frame ended inside a prefix: the previous symbol (if any)
            // already closed without end-of-frame, nothing more to emit.
            r_trunc_err   <= 1'b1;
            r_state       <= S_CP;
            r_cnt         <= '0;
            r_frame_start <= 1'b1;
          end else if (w_cp_end) begin
            r_state <= S_DATA;
            r_cnt   <= '0;
          end else begin
            r_state <= S_CP;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end else begin
          // ---------------- DATA: sample is forwarded ----------------
          r_tdata  <= i_axis.tdata;
          r_tvalid <= 1'b1;
          r_tlast  <= w_sym_end | i_axis.tlast;
          r_teof   <= i_axis.tlast;

          if (w_sym_end) begin
            r_sym_count <= w_sym_inc;
          end

          if (i_axis.tlast) begin
            // Ending mid-symbol closes a short packet and flags truncation.
            r_trunc_err   <= ~w_sym_end;
            r_state       <= S_CP;
            r_cnt         <= '0;
            r_frame_start <= 1'b1;
          end else if (w_sym_end) begin
            r_cnt   <= '0;
            r_state <= (w_cp_eff == '0) ? S_DATA : S_CP;
          end else begin
            r_state <= S_DATA;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign i_axis.tready = w_in_ready;
  assign o_axis.tdata  = r_tdata;
  assign o_axis.tlast  = r_tlast;
  assign o_axis.tvalid = r_tvalid;
  assign o_teof        = r_teof;
  assign sym_count     = r_sym_count;
  assign trunc_err     = r_trunc_err;

endmodule : ofdm_cp_remover

// File: tb/tb_ofdm_cp_remover.sv
// ---------------------------------------------------------------------------
// tb_ofdm_cp_remover
//   Directed frames through the CP remover. Expected beats come from a small
//   reference model of CP stripping; symbol counts and truncation pulses are
//   hand-computed per frame.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ofdm_cp_remover;

  localparam int W   = 32;
  localparam int FFT = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [7:0]  cp_len;
  logic        teof;
  logic [15:0] sym_count;
  logic        trunc_err;

  ofdm_cp_remover_if #(.WIDTH(W)) in_if ();
  ofdm_cp_remover_if #(.WIDTH(W)) out_if ();

  ofdm_cp_remover #(
    .WIDTH      (W),
    .FFT_LEN    (FFT),
    .MAX_CP_LOG2(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .cp_len   (cp_len),
    .i_axis   (in_if),
    .o_axis   (out_if),
    .o_teof   (teof),
    .sym_count(sym_count),
    .trunc_err(trunc_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- output monitor ----------------
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  int          trunc_hi   = 0;
  int          trunc_rise = 0;
  logic        trunc_prev = 1'b0;
  logic        rand_en    = 1'b0;

  always @(negedge clk) begin
    if (!reset && out_if.tvalid && out_if.tready)
      got_q.push_back({out_if.tdata, out_if.tlast, teof});
    if (trunc_err === 1'b1) trunc_hi++;
    if (trunc_err === 1'b1 && trunc_prev !== 1'b1) trunc_rise++;
    trunc_prev = trunc_err;
  end

  // Output backpressure driver.
  initial begin
    out_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_if.tready = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic [31:0] sample(input int tid, input int idx);
    return {8'(tid), 8'h00, 16'(idx)};
  endfunction

  // Reference: keep samples past the CP of each symbol; tlast at end of
  // symbol or at end of frame; teof only at end of frame.
  task automatic build_exp(input int tid, input int cp, input int n, input bit has_last);
    int per;
    exp_q.delete();
    per = cp + FFT;
    for (int idx = 0; idx < n; idx++) begin
      int  pos;
      bit  lst;
      pos = idx % per;
      lst = has_last && (idx == n - 1);
      if (pos >= cp)
        exp_q.push_back({sample(tid, idx), 1'(pos == per - 1 || lst), 1'(lst)});
    end
  endtask

  task automatic send_frame(input int tid, input int cp_a, input int cp_b, input int change_at,
                            input int n, input bit has_last, input bit chk_rdy);
    for (int idx = 0; idx < n; idx++) begin
      bit acc;
      cp_len       = 8'((idx < change_at) ? cp_a : cp_b);
      in_if.tdata  = sample(tid, idx);
      in_if.tlast  = has_last && (idx == n - 1);
      in_if.tvalid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 200 && !acc; c++) begin
        @(negedge clk);
        if (chk_rdy && ((idx % (cp_a + FFT)) < cp_a))
          check_val("cp_ready", 64'(in_if.tready), 64'd1);
        acc = in_if.tready;
        @(posedge clk);
        #1;
      end
      if (!acc) begin
        check_val("accept_timeout", 64'd0, 64'd1);
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        return;
      end
    end
    in_if.tvalid = 1'b0;
    in_if.tlast  = 1'b0;
  endtask

  task automatic run_frame(input int tid, input int cp_a, input int cp_b, input int change_at,
                           input int n, input bit has_last, input bit rnd,
                           input int exp_sym, input int exp_trunc);
    int rise0;
    int hi0;
    got_q.delete();
    rise0   = trunc_rise;
    hi0     = trunc_hi;
    rand_en = rnd;
    build_exp(tid, cp_a, n, has_last);
    send_frame(tid, cp_a, cp_b, change_at, n, has_last, rnd);
    for (int c = 0; c < 2000 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (6) @(posedge clk);
    rand_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val($sformatf("t%0d_beats", tid), 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_val($sformatf("t%0d_beat%0d", tid, i), 64'(got_q[i]), 64'(exp_q[i]));
    check_val($sformatf("t%0d_sym_count", tid), 64'(sym_count), 64'(exp_sym));
    check_val($sformatf("t%0d_trunc_pulses", tid), 64'(trunc_rise - rise0), 64'(exp_trunc));
    check_val($sformatf("t%0d_trunc_cycles", tid), 64'(trunc_hi - hi0), 64'(exp_trunc));
    $display("frame t=%0d cp=%0d n=%0d beats=%0d sym_count=%0d", tid, cp_a, n,
             got_q.size(), sym_count);
  endtask

  initial begin
    reset        = 1'b1;
    clear        = 1'b0;
    cp_len       = 8'd16;
    in_if.tdata  = '0;
    in_if.tlast  = 1'b0;
    in_if.tvalid = 1'b0;
    #1;
    check_val("rst_tvalid",    64'(out_if.tvalid), 64'd0);
    check_val("rst_tdata",     64'(out_if.tdata),  64'd0);
    check_val("rst_tlast",     64'(out_if.tlast),  64'd0);
    check_val("rst_teof",      64'(teof),          64'd0);
    check_val("rst_sym_count", 64'(sym_count),     64'd0);
    check_val("rst_trunc",     64'(trunc_err),     64'd0);
    check_val("rst_i_tready",  64'(in_if.tready),  64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // 1: three full symbols, CP 16
    run_frame(1, 16, 16, 9999, 240, 1'b1, 1'b0, 3, 0);
    // 2: zero CP, output identical to input
    run_frame(2, 0, 0, 9999, 128, 1'b1, 1'b0, 2, 0);
    // 3: frame ends in DATA of symbol 2 -> 24-beat short packet
    run_frame(3, 16, 16, 9999, 120, 1'b1, 1'b0, 1, 1);
    // 4: frame ends in CP of symbol 2 -> only 64 beats
    run_frame(4, 16, 16, 9999, 86, 1'b1, 1'b0, 1, 1);

    // synchronous clear drops the held symbol count
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    check_val("clear_sym_count", 64'(sym_count), 64'd0);
    check_val("clear_tvalid",    64'(out_if.tvalid), 64'd0);

    // 5: random output backpressure
    run_frame(5, 16, 16, 9999, 240, 1'b1, 1'b1, 3, 0);
    // 6a: cp_len changes mid-frame, latched 16 stays in force
    run_frame(6, 16, 8, 50, 160, 1'b1, 1'b0, 2, 0);
    // 6b: next frame picks up 8
    run_frame(7, 8, 8, 9999, 144, 1'b1, 1'b0, 2, 0);

    // 6c: asynchronous reset in the middle of a symbol
    send_frame(8, 16, 16, 9999, 40, 1'b0, 1'b0);
    check_val("held_beat_before_rst", 64'(out_if.tvalid), 64'd1);
    reset = 1'b1;
    #1;
    check_val("async_rst_tvalid", 64'(out_if.tvalid), 64'd0);
    check_val("async_rst_tdata",  64'(out_if.tdata),  64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_frame(9, 16, 16, 9999, 240, 1'b1, 1'b0, 3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ofdm_cp_remover
